fifo_wr_ptr: RTL and testbench

FIFO_WR_PTR -- requirements
Module: fifo_wr_ptr

---
 rtl/fifo_wr_ptr.sv | 80 ++++++++
 tb/tb_fifo_wr_ptr.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr.sv
// Write-side pointer and flag logic for an async FIFO; mem_we is combinational, all flags register one cycle after the push or read-pointer change.
// Backpressure: pushes are refused while wr_full is set, and any refused attempt latches the sticky wr_overflow.
module fifo_wr_ptr #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   wr_rdptr_gray,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  wr_overflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] AFULL_V = PW'(AFULL_THRESH);

   logic                wr_push;
   logic [ADDR_WIDTH:0] wbin_q, wbin_d;
   logic [ADDR_WIDTH:0] wr_ptr_gray_q, wr_ptr_gray_d;
   logic [ADDR_WIDTH:0] wr_count_q, wr_count_d;
   logic                wr_full_q, wr_full_d;
   logic                wr_almost_full_q, wr_almost_full_d;
   logic                wr_overflow_q, wr_overflow_d;
   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] occ;

   assign wr_push = wr_en & ~wr_full_q;

   always_comb begin
      wbin_d        = wr_push ? wbin_q + ONE : wbin_q;
      wr_ptr_gray_d = wbin_d ^ (wbin_d >> 1);

      // Each binary bit is the XOR of all Gray bits at or above it.
      rbin = '0;
      for (int i = 0; i < PW; i++) begin
         rbin[i] = ^(wr_rdptr_gray >> i);
      end

      occ              = wbin_d - rbin;
      wr_count_d       = occ;
      wr_full_d        = (wr_ptr_gray_d == {~wr_rdptr_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                                             wr_rdptr_gray[ADDR_WIDTH-2:0]});
      wr_almost_full_d = (occ >= AFULL_V);
      wr_overflow_d    = wr_overflow_q | (wr_en & wr_full_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_q           <= '0;
         wr_ptr_gray_q    <= '0;
         wr_count_q       <= '0;
         wr_full_q        <= 1'b0;
         wr_almost_full_q <= 1'b0;
         wr_overflow_q    <= 1'b0;
      end else begin
         wbin_q           <= wbin_d;
         wr_ptr_gray_q    <= wr_ptr_gray_d;
         wr_count_q       <= wr_count_d;
         wr_full_q        <= wr_full_d;
         wr_almost_full_q <= wr_almost_full_d;
         wr_overflow_q    <= wr_overflow_d;
      end
   end

   assign mem_we         = wr_push;
   assign wr_addr        = wbin_q[ADDR_WIDTH-1:0];
   assign wr_ptr_gray    = wr_ptr_gray_q;
   assign wr_full        = wr_full_q;
   assign wr_almost_full = wr_almost_full_q;
   assign wr_count       = wr_count_q;
   assign wr_overflow    = wr_overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// Self-checking bench for fifo_wr_ptr (ADDR_WIDTH=4, AFULL_THRESH=12): directed vector table,
// async-reset and lap-wrap sequences, then random traffic against an occupancy-count model.
module tb_fifo_wr_ptr;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [4:0] wr_rdptr_gray;
   logic       mem_we;
   logic [3:0] wr_addr;
   logic [4:0] wr_ptr_gray;
   logic       wr_full;
   logic       wr_almost_full;
   logic [4:0] wr_count;
   logic       wr_overflow;

   fifo_wr_ptr #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_rdptr_gray  (wr_rdptr_gray),
      .mem_we         (mem_we),
      .wr_addr        (wr_addr),
      .wr_ptr_gray    (wr_ptr_gray),
      .wr_full        (wr_full),
      .wr_almost_full (wr_almost_full),
      .wr_count       (wr_count),
      .wr_overflow    (wr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] gray5(input int n);
      logic [4:0] b;
      b = 5'(n % 32);
      return b ^ (b >> 1);
   endfunction

   typedef struct {
      logic       en;
      logic [4:0] rdg;
      logic       we;
      logic [3:0] addr;
      logic [4:0] gray;
      logic [4:0] cnt;
      logic       full;
      logic       afull;
      logic       ovf;
   } vec_t;

   vec_t tv[21];

   // Model state: totals of accepted pushes and of read-pointer advances.
   int   wr_total;
   int   rd_total;
   logic m_full;
   logic m_ovf;
   int   wraps;

   task automatic cyc(input logic en, input logic adv);
      int         occ;
      logic [4:0] pg;
      logic [3:0] pa;
      wr_en = en;
      if (adv && rd_total < wr_total) rd_total++;
      wr_rdptr_gray = gray5(rd_total);
      #1;
      chk("mem_we", int'(mem_we), int'(en && !m_full));
      chk("wr_addr", int'(wr_addr), wr_total % 16);
      pg = wr_ptr_gray;
      pa = wr_addr;
      if (en && m_full) m_ovf = 1'b1;
      if (en && !m_full) wr_total++;
      occ    = wr_total - rd_total;
      m_full = (occ == 16);
      @(posedge clk);
      #1;
      chk("wr_ptr_gray", int'(wr_ptr_gray), int'(gray5(wr_total)));
      chk("wr_count", int'(wr_count), occ);
      chk("wr_full", int'(wr_full), int'(occ == 16));
      chk("wr_almost_full", int'(wr_almost_full), int'(occ >= 12));
      chk("wr_overflow", int'(wr_overflow), int'(m_ovf));
      if (wr_ptr_gray != pg)
         chk("gray_hamming", $countones(wr_ptr_gray ^ pg), 1);
      if (pa == 4'd15 && wr_addr == 4'd0) wraps++;
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         tv[i] = '{1'b1, 5'd0, 1'b1, 4'(i), gray5(i + 1), 5'(i + 1),
                   (i == 15), (i + 1 >= 12), 1'b0};
      for (int i = 16; i < 19; i++)
         tv[i] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1};
      tv[19] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 5'd15, 1'b0, 1'b1, 1'b1};
      tv[20] = '{1'b1, 5'b00001, 1'b1, 4'd0, 5'b11001, 5'd16, 1'b1, 1'b1, 1'b1};

      rst = 1'b1;
      wr_en = 1'b0;
      wr_rdptr_gray = '0;
      #3;
      chk("rst_addr", int'(wr_addr), 0);
      chk("rst_gray", int'(wr_ptr_gray), 0);
      chk("rst_full", int'(wr_full), 0);
      chk("rst_afull", int'(wr_almost_full), 0);
      chk("rst_count", int'(wr_count), 0);
      chk("rst_ovf", int'(wr_overflow), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed table: fill to full, overflow attempts, one read, refill.
      for (int i = 0; i < 21; i++) begin
         wr_en = tv[i].en;
         wr_rdptr_gray = tv[i].rdg;
         #1;
         chk($sformatf("tv%0d_mem_we", i), int'(mem_we), int'(tv[i].we));
         chk($sformatf("tv%0d_addr", i), int'(wr_addr), int'(tv[i].addr));
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_gray", i), int'(wr_ptr_gray), int'(tv[i].gray));
         chk($sformatf("tv%0d_count", i), int'(wr_count), int'(tv[i].cnt));
         chk($sformatf("tv%0d_full", i), int'(wr_full), int'(tv[i].full));
         chk($sformatf("tv%0d_afull", i), int'(wr_almost_full), int'(tv[i].afull));
         chk($sformatf("tv%0d_ovf", i), int'(wr_overflow), int'(tv[i].ovf));
      end

      // Reset asserted between edges while pushing: outputs clear before the next edge.
      wr_en = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk("arst_addr", int'(wr_addr), 0);
      chk("arst_gray", int'(wr_ptr_gray), 0);
      chk("arst_full", int'(wr_full), 0);
      chk("arst_afull", int'(wr_almost_full), 0);
      chk("arst_count", int'(wr_count), 0);
      chk("arst_ovf", int'(wr_overflow), 0);
      chk("arst_mem_we", int'(mem_we), 1);
      wr_en = 1'b0;
      wr_rdptr_gray = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wr_total = 0;
      rd_total = 0;
      m_full = 1'b0;
      m_ovf = 1'b0;
      wraps = 0;

      // 40 pushes with the reader tracking: two address wraps, single-bit Gray steps.
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);
      chk("addr_wraps", wraps, 2);

      // Random traffic: first half biased toward filling, second half toward draining.
      for (int i = 0; i < 1500; i++) begin
         if (i < 750)
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
         else
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
